// File: rtl/uart_tx_fifo_if.sv
// Bus bundle for uart_tx_fifo: write port, FIFO status and the serial line.
// The master side enqueues characters; the slave side is the transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic                         wen;
  logic [DATA_W-1:0]            data;
  logic                         full;
  logic                         empty;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;
  logic                         tx;
  logic                         busy;

  modport master (
    output wen, data,
    input  full, empty, count, overflow, tx, busy
  );

  modport slave (
    input  wen, data,
    output full, empty, count, overflow, tx, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two FIFO: frames are start, DATA_W bits
// LSB first, optional parity and 1-2 stop bits, sent back to back while data waits.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BIT_RELOAD  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_RELOAD = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_W - 1);
  localparam bit                ODD_PAR     = (PARITY == 2);

  if (DATA_W < 5 || DATA_W > 8) begin : g_bad_data_w
    $error("uart_tx_fifo: DATA_W must be 5..8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                full, empty, push, pop;
  logic [DATA_W-1:0]   head;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign head         = mem_q[rd_ptr_q];
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = (state_q != ST_IDLE);

  // Writes are judged against the current full flag only, so a pop on the
  // same edge never frees room for a write that arrived while full.
  always_comb begin
    push       = bus.wen && !full;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.wen & full);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data;
  end

  // tx is registered: the edge that pops a word also drives the start bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      ST_START: begin
        if (baud_q == '0) begin
          state_d = ST_DATA;
          baud_d  = BIT_RELOAD;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BIT_RELOAD;
          if (bit_q == LAST_BIT) begin
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
              baud_d  = STOP_RELOAD;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_PARITY: begin
        if (baud_q == '0) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          baud_d  = STOP_RELOAD;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      state_d = ST_START;
      baud_d  = BIT_RELOAD;
      tx_d    = 1'b0;
      shift_d = head;
      par_d   = (^head) ^ ODD_PAR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three parity/stop configurations, FIFO
// fill/overflow, async reset mid-frame, pop-edge writes and pointer wrap.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if #(.DATA_W(8), .DEPTH(4)) bus0 ();
  uart_tx_fifo_if #(.DATA_W(8), .DEPTH(4)) bus1 ();
  uart_tx_fifo_if #(.DATA_W(8), .DEPTH(4)) bus2 ();

  uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Serial receiver for dut0 (even parity, one stop bit), sampling mid-bit on negedges.
  logic [7:0] rx_data [$];
  int         rx_start [$];
  int         rx_err = 0;
  logic       rx_active = 1'b0;
  int         rx_c = 0;
  logic [7:0] rx_sh = '0;
  logic       rx_par = 1'b0;
  logic       mon_en = 1'b0;
  logic [2:0] max_cnt = '0;

  always @(negedge clk) begin
    if (rst) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (bus0.tx === 1'b0) begin
        rx_active <= 1'b1;
        rx_c      <= 1;
        rx_start.push_back(cyc);
      end
    end else begin
      rx_c <= rx_c + 1;
      if (rx_c == 2 && bus0.tx !== 1'b0) rx_err <= rx_err + 1;
      if (rx_c >= 6 && rx_c <= 34 && (rx_c % 4) == 2) rx_sh[3'((rx_c - 6) / 4)] <= bus0.tx;
      if (rx_c == 38) rx_par <= bus0.tx;
      if (rx_c == 42 && bus0.tx !== 1'b1) rx_err <= rx_err + 1;
      if (rx_c == 43) begin
        rx_active <= 1'b0;
        rx_data.push_back(rx_sh);
        if (rx_par !== (^rx_sh)) rx_err <= rx_err + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && bus0.count > max_cnt) max_cnt <= bus0.count;
  end

  task step();
    @(posedge clk);
    #1;
  endtask

  task check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task apply_stimulus(input int sel, input logic [7:0] d);
    case (sel)
      0: begin bus0.wen = 1'b1; bus0.data = d; end
      1: begin bus1.wen = 1'b1; bus1.data = d; end
      default: begin bus2.wen = 1'b1; bus2.data = d; end
    endcase
    step();
    bus0.wen = 1'b0;
    bus1.wen = 1'b0;
    bus2.wen = 1'b0;
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? bus0.tx : (sel == 1) ? bus1.tx : bus2.tx;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus0.busy : (sel == 1) ? bus1.busy : bus2.busy;
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_data.size()) return rx_data[i];
    return 8'hxx;
  endfunction

  function automatic int gap_at(input int i);
    if (i + 1 < rx_start.size()) return rx_start[i+1] - rx_start[i];
    return -1;
  endfunction

  // Called right after the write edge; exp_bits[0] is the first bit on the line.
  task check_frame(input int sel, input string tag, input logic [10:0] exp_bits);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        if (tx_of(sel) !== exp_bits[b] || busy_of(sel) !== 1'b1) ok = 1'b0;
      end
    end
    check_output({tag, "_frame_bits"}, 32'(ok), 32'd1);
    step();
    check_output({tag, "_busy_after"}, 32'(busy_of(sel)), 32'd0);
    check_output({tag, "_tx_idle_after"}, 32'(tx_of(sel)), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] exp_q [$];
    logic [7:0] wd;

    rst = 1'b1;
    bus0.wen = 1'b0; bus0.data = '0;
    bus1.wen = 1'b0; bus1.data = '0;
    bus2.wen = 1'b0; bus2.data = '0;

    // Reset values must appear before any clock edge.
    #2;
    check_output("rst_tx", 32'(bus0.tx), 32'd1);
    check_output("rst_busy", 32'(bus0.busy), 32'd0);
    check_output("rst_empty", 32'(bus0.empty), 32'd1);
    check_output("rst_full", 32'(bus0.full), 32'd0);
    check_output("rst_count", 32'(bus0.count), 32'd0);
    check_output("rst_overflow", 32'(bus0.overflow), 32'd0);

    bus0.wen = 1'b1; bus0.data = 8'h99;
    step();
    step();
    check_output("write_during_rst", 32'(bus0.count), 32'd0);
    bus0.wen = 1'b0;
    rst = 1'b0;
    step();

    // Even parity, 0xA5: latency one edge, 44-cycle frame.
    apply_stimulus(0, 8'hA5);
    check_output("even_count_after_write", 32'(bus0.count), 32'd1);
    check_output("even_tx_before_pop", 32'(bus0.tx), 32'd1);
    check_frame(0, "even", 11'b10101001010);
    check_output("even_empty_after", 32'(bus0.empty), 32'd1);

    apply_stimulus(1, 8'hA5);
    check_frame(1, "odd", 11'b11101001010);
    apply_stimulus(2, 8'hA5);
    check_frame(2, "nopar_stop2", 11'b11101001010);

    // Back-to-back fill of a depth-4 FIFO; the first word pops immediately.
    rx_data.delete();
    rx_start.delete();
    apply_stimulus(0, 8'h11);
    check_output("b2b_count1", 32'(bus0.count), 32'd1);
    apply_stimulus(0, 8'h22);
    check_output("b2b_count2", 32'(bus0.count), 32'd1);
    check_output("b2b_tx_start", 32'(bus0.tx), 32'd0);
    apply_stimulus(0, 8'h33);
    check_output("b2b_count3", 32'(bus0.count), 32'd2);
    apply_stimulus(0, 8'h44);
    check_output("b2b_count4", 32'(bus0.count), 32'd3);
    apply_stimulus(0, 8'h55);
    check_output("b2b_count5", 32'(bus0.count), 32'd4);
    check_output("b2b_full", 32'(bus0.full), 32'd1);
    check_output("b2b_no_overflow", 32'(bus0.overflow), 32'd0);
    apply_stimulus(0, 8'h66);
    check_output("b2b_overflow", 32'(bus0.overflow), 32'd1);
    check_output("b2b_count_after_drop", 32'(bus0.count), 32'd4);
    for (int i = 0; i < 400; i++) begin
      if (rx_data.size() == 5 && !bus0.busy) break;
      step();
    end
    check_output("b2b_frames", 32'(rx_data.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      wd = 8'h11 * 8'(i + 1);
      check_output($sformatf("b2b_data%0d", i), 32'(rx_at(i)), 32'(wd));
    end
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("b2b_gap%0d", i), 32'(gap_at(i)), 32'd44);
    end
    check_output("b2b_rx_err", 32'(rx_err), 32'd0);

    // Async reset during the DATA state of 0x5A.
    rx_data.delete();
    rx_start.delete();
    apply_stimulus(0, 8'h5A);
    repeat (6) step();
    check_output("rstmid_tx_d0", 32'(bus0.tx), 32'd0);
    check_output("rstmid_overflow_sticky", 32'(bus0.overflow), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_output("rstmid_tx", 32'(bus0.tx), 32'd1);
    check_output("rstmid_count", 32'(bus0.count), 32'd0);
    check_output("rstmid_busy", 32'(bus0.busy), 32'd0);
    check_output("rstmid_overflow", 32'(bus0.overflow), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check_output("rstmid_idle", 32'(bus0.busy), 32'd0);
    rx_data.delete();
    rx_start.delete();
    apply_stimulus(0, 8'h3C);
    for (int i = 0; i < 100; i++) begin
      if (rx_data.size() == 1 && !bus0.busy) break;
      step();
    end
    check_output("rstmid_frames", 32'(rx_data.size()), 32'd1);
    check_output("rstmid_data", 32'(rx_at(0)), 32'h3C);
    check_output("rstmid_rx_err", 32'(rx_err), 32'd0);

    // Write landing on the end-of-stop pop edge with one word queued.
    rx_data.delete();
    rx_start.delete();
    apply_stimulus(0, 8'h81);
    step();
    apply_stimulus(0, 8'h42);
    check_output("popedge_count_before", 32'(bus0.count), 32'd1);
    repeat (42) step();
    check_output("popedge_last_stop_tx", 32'(bus0.tx), 32'd1);
    apply_stimulus(0, 8'hE7);
    check_output("popedge_count", 32'(bus0.count), 32'd1);
    check_output("popedge_tx_start", 32'(bus0.tx), 32'd0);
    check_output("popedge_busy", 32'(bus0.busy), 32'd1);
    for (int i = 0; i < 200; i++) begin
      if (rx_data.size() == 3 && !bus0.busy) break;
      step();
    end
    check_output("popedge_frames", 32'(rx_data.size()), 32'd3);
    check_output("popedge_data0", 32'(rx_at(0)), 32'h81);
    check_output("popedge_data1", 32'(rx_at(1)), 32'h42);
    check_output("popedge_data2", 32'(rx_at(2)), 32'hE7);
    check_output("popedge_gap0", 32'(gap_at(0)), 32'd44);
    check_output("popedge_gap1", 32'(gap_at(1)), 32'd44);

    // Twelve writes interleaved with transmission so both pointers wrap.
    rx_data.delete();
    rx_start.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wd = 8'((i * 37 + 5) & 255);
      exp_q.push_back(wd);
      for (int t = 0; t < 200 && bus0.full; t++) step();
      apply_stimulus(0, wd);
      repeat ($urandom_range(0, 30)) step();
    end
    for (int i = 0; i < 1000; i++) begin
      if (rx_data.size() == 12 && !bus0.busy) break;
      step();
    end
    check_output("wrap_frames", 32'(rx_data.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      check_output($sformatf("wrap_data%0d", i), 32'(rx_at(i)), 32'(exp_q[i]));
    end
    check_output("wrap_max_count_le_depth", 32'(max_cnt <= 3'd4), 32'd1);
    check_output("wrap_max_count_reached", 32'(max_cnt), 32'd4);
    check_output("wrap_no_overflow", 32'(bus0.overflow), 32'd0);
    check_output("wrap_empty", 32'(bus0.empty), 32'd1);
    check_output("wrap_rx_err", 32'(rx_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the character width; legal 5..8.
REQ-002 Parameter DEPTH, default 16, SHALL set the FIFO depth; power of two, at least 2.
REQ-003 Parameter CLKS_PER_BIT, default 10, SHALL set the number of clk cycles per serial bit; at least 2.
REQ-004 Parameter PARITY, default 0, SHALL select the parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, SHALL set the stop-bit count; legal 1 or 2.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-008 wen  input  1  SHALL request a write of data into the FIFO.
REQ-009 data  input  DATA_W  SHALL carry the character to enqueue.
REQ-010 full  output  1  SHALL be high when count equals DEPTH.
REQ-011 empty  output  1  SHALL be high when count equals 0.
REQ-012 count  output  $clog2(DEPTH+1)  SHALL report the FIFO occupancy.
REQ-013 overflow  output  1  SHALL be a sticky flag for writes attempted while full.
REQ-014 tx  output  1  SHALL be the serial line, idle high.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-016 A write with wen=1 and full=0 SHALL store data at the write pointer, and count SHALL reflect it after the same edge.
REQ-017 A write with wen=1 and full=1 SHALL be dropped, SHALL leave FIFO contents unchanged, and SHALL set overflow.
REQ-018 Pointers SHALL wrap modulo DEPTH.
REQ-019 A write and a pop on the same edge SHALL leave count unchanged.
REQ-020 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-021 IDLE with empty=0 SHALL pop the head word into the shift register, enter START and drive tx=0 on the same edge.
REQ-022 Each bit state SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded with CLKS_PER_BIT-1.
REQ-023 DATA SHALL shift out DATA_W bits LSB first, then go to PARITY if PARITY!=0, else to STOP.
REQ-024 The parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity, computed from the popped word.
REQ-025 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-026 At the end of STOP the FSM SHALL either pop the next word and enter START on the same edge (no idle gap) if empty=0, or go to IDLE if empty=1.
REQ-027 Frame length SHALL be (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-028 Latency: a write into an empty FIFO with the FSM in IDLE at edge k SHALL produce tx falling at edge k+1.
REQ-029 The FIFO SHALL accept writes at any FSM state, including the pop edge.
REQ-030 Parameter values outside their legal range SHALL be rejected at elaboration.

Reset
REQ-031 While rst=1, independent of clk: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, tx=1, busy=0, bit and baud counters=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame, return tx high immediately and discard all FIFO contents.
REQ-033 Reset release SHALL take effect at the first clk edge with rst=0; no write is accepted before that edge.

Verification
REQ-034 Config DATA_W=8, CLKS_PER_BIT=4, PARITY=1: write 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles, frame 44 cycles, busy low after.
REQ-035 Same write with PARITY=2 -> parity bit 1; with PARITY=0 and STOP_BITS=2 -> 11 bits, 44 cycles, last two bits high.
REQ-036 DEPTH=4: write 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back while idle -> first word pops at once, so all five are accepted, full=1, overflow=0; a further write sets overflow=1, and frames emit 0x11..0x55 with no gap cycles between stop and start.
REQ-037 Wrap test: 3*DEPTH writes interleaved with transmission -> output order matches input order, count never exceeds DEPTH.
REQ-038 Assert rst during the DATA state of 0x5A -> tx=1, count=0 and busy=0 asynchronously; the next write of 0x3C transmits cleanly.
REQ-039 Write on the same edge as the end-of-STOP pop with count=1 -> count stays 1, and the next frame starts with no gap.
